// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port arbiter sharing one data-memory port between the
// CPU (c_*) and a debug/loader port (d_*).
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   c_req..c_size       CPU command in; c_ack pulse and c_rdata out
//   d_req..d_size       debug command in; d_ack pulse and d_rdata out
//   m_en..m_size        memory command out (valid while m_en = 1)
//   m_rdata             memory read data, valid the cycle after m_en
//   halt                processor trap-halt (only used with DMEM_ARB_HALT_EN)
//   busy, owner         arbiter not idle; last-granted port (0 CPU, 1 debug)
//
// Build option: define DMEM_ARB_HALT_EN to keep the CPU from being granted
// while halt is high; otherwise halt is ignored.
//
// state | meaning
// IDLE  | waiting for an eligible request, arbitration happens here
// ISSUE | memory strobe driven with the registered command
// RESP  | ack pulse to the granted port, read data returned

module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic          c_we,
  input  logic [1:0]    c_size,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  output logic [1:0]    m_size,
  input  logic [DW-1:0] m_rdata,
  input  logic          halt,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state, state_nxt;
  logic          c_elig, d_elig;
  logic          gnt_c, gnt_d;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_we;
  logic [1:0]    cmd_size;
  logic [DW-1:0] c_rdata_q, d_rdata_q;

`ifdef DMEM_ARB_HALT_EN
  assign c_elig = c_req & ~halt;
`else
  logic unused_halt;
  assign unused_halt = halt;
  assign c_elig = c_req;
`endif
  assign d_elig = d_req;

  // owner doubles as the in-flight port select: it is written at grant and
  // holds through ISSUE and RESP.
  always_comb begin
    state_nxt = state;
    gnt_c     = 1'b0;
    gnt_d     = 1'b0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    c_ack     = 1'b0;
    d_ack     = 1'b0;
    c_rdata   = c_rdata_q;
    d_rdata   = d_rdata_q;
    case (state)
      IDLE: begin
        if (c_elig && d_elig) begin
          gnt_c = owner;
          gnt_d = ~owner;
        end else begin
          gnt_c = c_elig;
          gnt_d = d_elig;
        end
        if (gnt_c || gnt_d) state_nxt = ISSUE;
      end
      ISSUE: begin
        m_en      = 1'b1;
        m_we      = cmd_we;
        state_nxt = RESP;
      end
      RESP: begin
        c_ack     = ~owner;
        d_ack     = owner;
        // Memory data only exists in this cycle, so forward it straight out
        // during the ack and capture it for the following cycles.
        if (!cmd_we && !owner) c_rdata = m_rdata;
        if (!cmd_we && owner)  d_rdata = m_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= 1'b1;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_we    <= 1'b0;
      cmd_size  <= 2'b00;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_c) begin
        owner     <= 1'b0;
        cmd_addr  <= c_addr;
        cmd_wdata <= c_wdata;
        cmd_we    <= c_we;
        cmd_size  <= c_size;
      end else if (gnt_d) begin
        owner     <= 1'b1;
        cmd_addr  <= d_addr;
        cmd_wdata <= d_wdata;
        cmd_we    <= d_we;
        cmd_size  <= d_size;
      end
      c_rdata_q <= c_rdata;
      d_rdata_q <= d_rdata;
    end
  end

  assign m_addr  = cmd_addr;
  assign m_wdata = cmd_wdata;
  assign m_size  = cmd_size;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_ack, d_req, d_we, d_ack;
  logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
  logic [1:0]  c_size, d_size, m_size;
  logic        m_en, m_we, halt, busy, owner;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [31:0] mem [0:255];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] crd_exp, drd_exp;

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [8];

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
    .c_size(c_size), .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_size(d_size), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we),
    .m_size(m_size), .m_rdata(m_rdata),
    .halt(halt), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after m_en.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr[7:0]] <= m_wdata;
      else      m_rdata <= mem[m_addr[7:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_m_en"}, m_en, 1'b0);
    chk1({tag, "_m_we"}, m_we, 1'b0);
    chk1({tag, "_c_ack"}, c_ack, 1'b0);
    chk1({tag, "_d_ack"}, d_ack, 1'b0);
    chk({tag, "_c_rdata"}, c_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk1({tag, "_owner"}, owner, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic do_access(input logic dbg, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic [31:0] rd);
    int waited;
    @(negedge clk);
    if (dbg) begin
      d_addr = addr; d_wdata = wdata; d_we = we; d_size = size; d_req = 1'b1;
    end else begin
      c_addr = addr; c_wdata = wdata; c_we = we; c_size = size; c_req = 1'b1;
    end
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!m_en && waited < 8);
    chk("issue_latency", 32'(waited), 32'd1);
    chk1("m_we", m_we, we);
    chk("m_addr", m_addr, addr);
    if (we) chk("m_wdata", m_wdata, wdata);
    chk("m_size", 32'(m_size), 32'(size));
    chk1("owner", owner, dbg);
    chk1("busy_issue", busy, 1'b1);
    @(negedge clk);
    chk1("ack", dbg ? d_ack : c_ack, 1'b1);
    chk1("other_ack", dbg ? c_ack : d_ack, 1'b0);
    chk1("m_en_resp", m_en, 1'b0);
    if (!we) begin
      if (dbg) drd_exp = rd;
      else     crd_exp = rd;
    end
    chk("c_rdata", c_rdata, crd_exp);
    chk("d_rdata", d_rdata, drd_exp);
    c_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    chk1("ack_drop", c_ack | d_ack, 1'b0);
    chk1("busy_idle", busy, 1'b0);
    chk("c_rdata_hold", c_rdata, crd_exp);
    chk("d_rdata_hold", d_rdata, drd_exp);
  endtask

  initial begin
    int nack, cyc, last;
    logic seen;

    vt[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h10, 32'h0,        2'b10, 32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 2'b01, 32'h0};
    vt[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        2'b10, 32'h12345678};
    vt[4] = '{1'b0, 1'b0, 32'h20, 32'h0,        2'b10, 32'h12345678};
    vt[5] = '{1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 2'b00, 32'h0};
    vt[6] = '{1'b0, 1'b1, 32'h24, 32'h000000A5, 2'b10, 32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h10, 32'h0,        2'b10, 32'hCAFEF00D};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    m_rdata = 32'h0;
    rst = 1'b0; halt = 1'b0;
    c_req = 1'b0; c_addr = 32'h0; c_wdata = 32'h0; c_we = 1'b0; c_size = 2'b00;
    d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 1'b0; d_size = 2'b00;
    crd_exp = 32'h0; drd_exp = 32'h0;

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;

    // Directed single-port accesses.
    for (int i = 0; i < 8; i++)
      do_access(vt[i].dbg, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].rd);

    // Both ports requesting continuously from reset: C,D,C,D,... 3 cycles apart.
    @(negedge clk);
    rst = 1'b0;
    #1 chk_reset("reset2");
    @(negedge clk);
    rst = 1'b1;
    c_addr = 32'h10; c_we = 1'b0; c_size = 2'b10;
    d_addr = 32'h20; d_we = 1'b0; d_size = 2'b10;
    c_req = 1'b1; d_req = 1'b1;
    nack = 0; cyc = 0; last = 0;
    while (nack < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk1("m_en_with_ack", m_en & (c_ack | d_ack), 1'b0);
      chk1("m_en_without_busy", m_en & ~busy, 1'b0);
      chk1("dual_ack", c_ack & d_ack, 1'b0);
      if (c_ack || d_ack) begin
        chk1("rr_order", d_ack, nack[0]);
        if (nack == 0) chk("first_ack_latency", 32'(cyc), 32'd2);
        else           chk("ack_spacing", 32'(cyc - last), 32'd3);
        if (c_ack) chk("rr_c_rdata", c_rdata, 32'hCAFEF00D);
        else       chk("rr_d_rdata", d_rdata, 32'h12345678);
        last = cyc;
        nack++;
        if (nack == 8) begin
          c_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    chk("rr_ack_count", 32'(nack), 32'd8);
    chk1("rr_owner_end", owner, 1'b1);
    crd_exp = 32'hCAFEF00D;
    drd_exp = 32'h12345678;

    // Reset during ISSUE aborts a write; nothing acks afterwards.
    @(negedge clk);
    c_addr = 32'h24; c_wdata = 32'h00000BAD; c_we = 1'b1; c_size = 2'b10; c_req = 1'b1;
    @(negedge clk);
    chk1("abort_m_en_before", m_en, 1'b1);
    #2 rst = 1'b0;
    #1 chk_reset("abort");
    c_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    crd_exp = 32'h0; drd_exp = 32'h0;
    repeat (4) begin
      @(negedge clk);
      chk1("abort_no_ack", c_ack | d_ack, 1'b0);
      chk1("abort_no_m_en", m_en, 1'b0);
    end
    do_access(1'b0, 1'b0, 32'h24, 32'h0, 2'b10, 32'h000000A5);

`ifdef DMEM_ARB_HALT_EN
    // Halted CPU is never granted; debug keeps getting served.
    @(negedge clk);
    halt = 1'b1;
    c_addr = 32'h10; c_we = 1'b0; c_size = 2'b10;
    d_addr = 32'h20; d_we = 1'b0; d_size = 2'b10;
    c_req = 1'b1; d_req = 1'b1;
    nack = 0; cyc = 0;
    while (nack < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      chk1("halt_no_c_ack", c_ack, 1'b0);
      if (d_ack) nack++;
    end
    chk("halt_d_acks", 32'(nack), 32'd3);
    halt = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3 && !seen; k++) begin
      @(negedge clk);
      if (c_ack) seen = 1'b1;
    end
    chk1("cpu_after_halt", seen, 1'b1);
    chk("cpu_after_halt_rdata", c_rdata, 32'hCAFEF00D);
    c_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk1("halt_quiet", busy, 1'b0);
`else
    // halt has no effect in this build.
    halt = 1'b1;
    seen = 1'b0;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 32'hCAFEF00D);
    halt = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width of all address ports.
REQ-002 Parameter DW, default 32, data width of all data ports.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 c_req  input  1  CPU port request; held high until c_ack.
REQ-006 c_addr/c_wdata/c_we/c_size  input  AW/DW/1/2  CPU command; c_size 00 byte, 01 half, 10 word.
REQ-007 c_ack  output  1  CPU completion pulse; c_rdata (output, DW) holds read data.
REQ-008 d_req, d_addr, d_wdata, d_we, d_size, d_ack, d_rdata  same directions and widths as the CPU set  debug/loader port.
REQ-009 m_en  output  1  memory strobe; m_addr/m_wdata/m_we/m_size (outputs, AW/DW/1/2) form the memory command.
REQ-010 m_rdata  input  DW  memory read data, valid in the cycle after m_en.
REQ-011 halt  input  1  processor trap-halt indication.
REQ-012 busy  output  1  high in any state other than IDLE; owner  output  1  0 = CPU, 1 = debug, last-granted port.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE on any eligible request; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 In IDLE with exactly one eligible request, that port SHALL be granted.
REQ-015 In IDLE with both ports requesting, the port that is not owner SHALL be granted (round robin).
REQ-016 On grant, the granted command SHALL be registered; owner SHALL update to the granted port.
REQ-017 In ISSUE, m_en SHALL be 1 and m_addr/m_wdata/m_we/m_size SHALL equal the registered command; in all other states m_en = 0 and m_we = 0.
REQ-018 In RESP, the granted port's ack SHALL be 1 for exactly one cycle, and its rdata SHALL load m_rdata for reads or remain unchanged for writes.
REQ-019 Latency: request sampled at edge N -> m_en high during cycle N+1 -> ack high during cycle N+2; minimum 3 cycles between grants.
REQ-020 The requester SHALL drop req at the edge ending its ack cycle; req still high in the following IDLE SHALL be treated as a new request.
REQ-021 c_rdata/d_rdata SHALL hold their last value until that port's next read completes.
REQ-022 Requests arriving during ISSUE or RESP SHALL wait; none SHALL be lost or duplicated.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rst low SHALL immediately force IDLE, m_en = 0, m_we = 0, c_ack = d_ack = 0, c_rdata = d_rdata = 0, owner = 1 (CPU wins first tie), busy = 0.
REQ-025 Reset during ISSUE SHALL abort the access, and no ack SHALL be produced for it after reset release.

Configuration
REQ-026 Macro DMEM_ARB_HALT_EN: when defined, halt = 1 SHALL make c_req ineligible in IDLE (an in-flight CPU access completes normally) while d_req is served every grant.
REQ-027 Without DMEM_ARB_HALT_EN, the halt port SHALL exist but be ignored.

Verification
REQ-028 Reset release, then c_req write of addr 0x10, data 0xDEADBEEF, size 10 -> m_en/m_we high one cycle with those values, c_ack exactly 2 cycles after sampling.
REQ-029 Then c_req read of 0x10 with the memory model returning 0xDEADBEEF -> c_ack pulse, c_rdata = 0xDEADBEEF, d_rdata stays 0.
REQ-030 c_req and d_req raised together after reset -> CPU granted first, debug second, owner ends at 1, each ack exactly once.
REQ-031 Both ports requesting continuously for 4 accesses each -> grant order C,D,C,D,...; no m_en in IDLE/RESP.
REQ-032 rst pulsed low during ISSUE -> outputs clear asynchronously, no ack afterwards; next c_req served normally.
REQ-033 With DMEM_ARB_HALT_EN and halt = 1, both ports requesting -> only debug acked; CPU acked within 3 cycles of halt dropping.
